ext_int_conditioner: RTL and testbench
======================================

# ext_int_conditioner

Per-channel conditioner for asynchronous external interrupt pins (PMOD header lines, switches) before they reach the core's `io_int_exts_*` inputs in the board top. It replaces the direct pin-to-core wiring used so far with a parametrised block: N channels, each with a 2-flop synchroniser, a debounce filter and a run-time edge-mode select. Each channel produces a one-cycle interrupt pulse, a pending flag with acknowledge, and a sticky overflow flag. It sits in the board top between the pins and `FpgaTop`, clocked by the clock-wizard output.

## Interface

Parameters:
- `N_CH`, 2 — number of channels.
- `DEBOUNCE_CYCLES`, 16 — consecutive cycles a new level must persist before acceptance; legal range 1..2^16-1; 1 means no filtering.
- `IDLE_LEVEL`, `{N_CH{1'b0}}` — per-channel reset value of the synchroniser and stable registers.

Ports:
- `clock` in 1 — system clock.
- `reset` in 1 — synchronous, active-high.
- `pins_in` in N_CH — raw asynchronous pin levels.
- `mode` in 2*N_CH — per channel `[2c+1:2c]`: 00 disabled, 01 rising, 10 falling, 11 both edges.
- `ack` in N_CH — clears pending and overflow of the channel.
- `int_pulse` out N_CH — one-cycle event pulse; to core `io_int_exts`.
- `pending` out N_CH — latched event flag.
- `overflow` out N_CH — sticky: event arrived while pending was already set.
- `level` out N_CH — debounced pin level.

## Operation

- Synchroniser: `s1 <= pins_in`, `s2 <= s1`. Reset value is `IDLE_LEVEL`.
- Debounce counter: 16 bits per channel.
  - When `s2 == stable`: counter <= 0.
  - Otherwise, if counter == `DEBOUNCE_CYCLES-1`: `stable <= s2` and counter <= 0.
  - Otherwise: counter++.
  - Reset: counter 0, `stable` = `IDLE_LEVEL`.
  - `level` = `stable`.
- Event detection:
  - `stable_d` is `stable` delayed one cycle. Its reset value is `IDLE_LEVEL`, so reset release generates no event.
  - rise = `stable & ~stable_d`; fall = `~stable & stable_d`.
  - The event is gated by `mode`; it is combinational from registers only.
  - `int_pulse` = event. It is glitch-free and lasts exactly one cycle per accepted transition.
- Pending and overflow per channel, in priority order:
  - event && pending && !ack → overflow <= 1; pending stays 1.
  - event → pending <= 1. This includes the case where ack is asserted in the same cycle: the event wins and overflow <= 0 if ack.
  - ack → pending <= 0, overflow <= 0.
- Mode changes take effect in the same cycle. Changing mode never creates an event by itself. Mode 00 suppresses events, but `level` keeps tracking the pin.
- Channels are fully independent. Simultaneous events on all channels are all reported in the same cycle.

## Timing

- Every output is 0 after reset, except `level` = `IDLE_LEVEL`.
- Pin level established before clock edge k:
  - `s2` valid after edge k+1.
  - `stable` updates at edge k+1+D, where D = `DEBOUNCE_CYCLES`.
  - `int_pulse` high for the cycle following edge k+1+D.
  - `pending` high after edge k+2+D.
- Glitches shorter than D cycles (as seen at `s2`) are discarded completely.
- If a bounce returns the pin to `stable` before the counter reaches D-1, the counter restarts from 0.
- Reset asserted mid-count abandons the count and any pending or overflow state in one cycle. No pulse is emitted on that cycle or after release unless the pin differs from `IDLE_LEVEL`.
- Counter wrap is impossible: the counter saturates at D-1 by construction.

## Structure

- Package `ext_int_pkg`: mode encoding constants (`MODE_OFF`, `MODE_RISE`, `MODE_FALL`, `MODE_BOTH`) and the counter width constant `DB_W = 16`.
- One sub-module, `ext_int_chan`: synchroniser, debounce, edge detect and pending/overflow for a single channel. The top module generates `N_CH` instances and slices `mode`.

## Test plan

- D=4, mode=01, ch0 pin 0→1 before edge 10 → `int_pulse[0]` high only in the cycle after edge 15, `pending[0]` after edge 16, `level[0]` = 1.
- D=4, ch0 pin high for 3 cycles, then low → no `int_pulse`, `level` stays 0, counter observed returning to 0.
- mode=11, clean rise, then a fall 20 cycles later → two single-cycle pulses; with no ack in between, `overflow[0]` = 1 after the second event; `ack` → both flags 0 the next cycle.
- Event and `ack` in the same cycle while pending=1 → `pending` stays 1, `overflow` = 0.
- `IDLE_LEVEL` = 1 with pin held high through reset → no pulse after release. mode=10 with the pin then dropping → one pulse; mode=00 with the pin dropping → no pulse, but `level` follows.
- Reset asserted 2 cycles into a D=8 count, then released with the pin back at idle → no pulse, all flags 0. N_CH=4 with simultaneous rises on all channels → 4 pulses in the same cycle.

Source files
------------

// File: rtl/ext_int_pkg.sv
// ext_int_pkg
// Shared definitions for the external interrupt conditioner:
//   - edge_mode_e : per-channel edge selection (off / rising / falling / both)
//   - DB_W        : width of each channel's debounce counter
//   - edge_enabled: decides whether a detected transition is reported
package ext_int_pkg;

  localparam int DB_W = 16;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } edge_mode_e;

  // A transition is reported only if the selected mode covers its direction.
  function automatic logic edge_enabled(input edge_mode_e mode,
                                        input logic rise,
                                        input logic fall);
    return (rise && (mode == MODE_RISE || mode == MODE_BOTH)) ||
           (fall && (mode == MODE_FALL || mode == MODE_BOTH));
  endfunction

endpackage

// File: rtl/ext_int_conditioner_if.sv
// ext_int_conditioner_if
// Bundles the pin-side inputs and core-side outputs of the conditioner.
//   pins_in   : raw asynchronous pin levels, one per channel
//   mode      : 2 bits per channel, [2c+1:2c]
//   ack       : clears pending/overflow of a channel
//   int_pulse : one-cycle event pulse per channel
//   pending   : latched event flag per channel
//   overflow  : sticky "event while pending" flag per channel
//   level     : debounced pin level per channel
// master drives the pins/mode/ack side, slave is the conditioner itself.
interface ext_int_conditioner_if #(
  parameter int N_CH = 2
);
  logic [N_CH-1:0]   pins_in;
  logic [2*N_CH-1:0] mode;
  logic [N_CH-1:0]   ack;
  logic [N_CH-1:0]   int_pulse;
  logic [N_CH-1:0]   pending;
  logic [N_CH-1:0]   overflow;
  logic [N_CH-1:0]   level;

  modport master (
    output pins_in, mode, ack,
    input  int_pulse, pending, overflow, level
  );

  modport slave (
    input  pins_in, mode, ack,
    output int_pulse, pending, overflow, level
  );
endinterface

// File: rtl/ext_int_chan.sv
// ext_int_chan
// One conditioned interrupt channel: 2-flop synchroniser, debounce filter,
// edge detection gated by mode, and pending/overflow bookkeeping.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   pin_in       : raw asynchronous pin
//   mode         : edge selection for this channel
//   ack          : clears pending and overflow
//   int_pulse    : one-cycle event pulse
//   pending      : latched event flag
//   overflow     : event arrived while pending was already set
//   level        : debounced pin level
module ext_int_chan
  import ext_int_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter logic IDLE_LEVEL      = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pin_in,
  input  edge_mode_e mode,
  input  logic       ack,
  output logic       int_pulse,
  output logic       pending,
  output logic       overflow,
  output logic       level
);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            s1;
  logic            s2;
  logic            stable;
  logic            stable_d;
  logic [DB_W-1:0] cnt;
  logic            rise;
  logic            fall;
  logic            evt;
  logic            pending_q;
  logic            overflow_q;

  // Two-flop synchroniser; resets to the idle level so release is quiet.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1 <= IDLE_LEVEL;
      s2 <= IDLE_LEVEL;
    end else begin
      s1 <= pin_in;
      s2 <= s1;
    end
  end

  // Debounce: a new level must be seen DEBOUNCE_CYCLES times in a row.
  // Any return to the stable level restarts the count, so it never wraps.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt    <= '0;
      stable <= IDLE_LEVEL;
    end else if (s2 == stable) begin
      cnt <= '0;
    end else if (cnt == DB_LAST) begin
      stable <= s2;
      cnt    <= '0;
    end else begin
      cnt <= cnt + DB_W'(1);
    end
  end

  // Previous stable level for edge detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      stable_d <= IDLE_LEVEL;
    end else begin
      stable_d <= stable;
    end
  end

  // Event is built from registers only, so the pulse is glitch-free.
  // Mode is applied here, so changing it alone can never make an edge.
  always_comb begin
    rise = stable & ~stable_d;
    fall = ~stable & stable_d;
    evt  = edge_enabled(mode, rise, fall);
  end

  // An event beats a same-cycle ack; an ack that coincides with an event
  // still clears a previous overflow.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else if (evt && pending_q && !ack) begin
      overflow_q <= 1'b1;
    end else if (evt) begin
      pending_q <= 1'b1;
      if (ack) begin
        overflow_q <= 1'b0;
      end
    end else if (ack) begin
      pending_q  <= 1'b0;
      overflow_q <= 1'b0;
    end
  end

  assign int_pulse = evt;
  assign pending   = pending_q;
  assign overflow  = overflow_q;
  assign level     = stable;

endmodule

// File: rtl/ext_int_conditioner.sv
// ext_int_conditioner
// N_CH independent interrupt conditioning channels between the board pins
// and the core's external interrupt inputs.
// Ports:
//   clock : system clock (clock-wizard output)
//   reset : synchronous active-high reset
//   bus   : slave side of ext_int_conditioner_if (pins_in, mode, ack in;
//           int_pulse, pending, overflow, level out)
module ext_int_conditioner
  import ext_int_pkg::*;
#(
  parameter int              N_CH            = 2,
  parameter int              DEBOUNCE_CYCLES = 16,
  parameter logic [N_CH-1:0] IDLE_LEVEL      = '0
) (
  input logic                  clock,
  input logic                  reset,
  ext_int_conditioner_if.slave bus
);

  logic [N_CH-1:0] pulse_v;
  logic [N_CH-1:0] pending_v;
  logic [N_CH-1:0] overflow_v;
  logic [N_CH-1:0] level_v;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    ext_int_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .IDLE_LEVEL     (IDLE_LEVEL[c])
    ) u_chan (
      .clock    (clock),
      .reset    (reset),
      .pin_in   (bus.pins_in[c]),
      .mode     (edge_mode_e'(bus.mode[2*c +: 2])),
      .ack      (bus.ack[c]),
      .int_pulse(pulse_v[c]),
      .pending  (pending_v[c]),
      .overflow (overflow_v[c]),
      .level    (level_v[c])
    );
  end

  assign bus.int_pulse = pulse_v;
  assign bus.pending   = pending_v;
  assign bus.overflow  = overflow_v;
  assign bus.level     = level_v;

endmodule

// File: tb/tb_ext_int_conditioner.sv
// tb_ext_int_conditioner
// Two conditioner instances side by side:
//   dut_a : 4 channels, debounce 4, idle level 0
//   dut_b : 2 channels, debounce 8, idle level 1 on both channels
// A reference model tracks, per channel, the recent history of the
// synchronised pin and accepts a new level once the last D samples all
// disagree with the current level; events and flags follow from that.
module tb_ext_int_conditioner;

  localparam int         NA     = 4;
  localparam int         DA     = 4;
  localparam logic [3:0] IDLE_A = 4'b0000;
  localparam int         NB     = 2;
  localparam int         DB     = 8;
  localparam logic [1:0] IDLE_B = 2'b11;

  logic clock = 1'b0;
  logic reset_a;
  logic reset_b;
  int   checks = 0;
  int   fails  = 0;

  always #5 clock = ~clock;

  ext_int_conditioner_if #(.N_CH(NA)) bus_a ();
  ext_int_conditioner_if #(.N_CH(NB)) bus_b ();

  ext_int_conditioner #(
    .N_CH(NA), .DEBOUNCE_CYCLES(DA), .IDLE_LEVEL(IDLE_A)
  ) dut_a (
    .clock(clock), .reset(reset_a), .bus(bus_a.slave)
  );

  ext_int_conditioner #(
    .N_CH(NB), .DEBOUNCE_CYCLES(DB), .IDLE_LEVEL(IDLE_B)
  ) dut_b (
    .clock(clock), .reset(reset_b), .bus(bus_b.slave)
  );

  // Reference model state, index 0 = dut_a, 1 = dut_b.
  int          m_n[2];
  int          m_d[2];
  logic [3:0]  m_idle[2];
  logic [3:0]  m_s1[2];
  logic [3:0]  m_s2[2];
  logic [3:0]  m_stable[2];
  logic [3:0]  m_prev[2];
  logic [3:0]  m_pend[2];
  logic [3:0]  m_ovf[2];
  logic [15:0] m_hist[2][4];

  // A channel reports when its accepted level changed and the mode covers
  // the direction it changed to.
  function automatic logic [3:0] m_event(input int d, input logic [7:0] mode);
    logic [3:0] ev;
    ev = '0;
    for (int c = 0; c < m_n[d]; c++) begin
      if (m_stable[d][c] != m_prev[d][c]) begin
        ev[c] = m_stable[d][c] ? mode[2*c] : mode[2*c+1];
      end
    end
    return ev;
  endfunction

  task automatic model_edge(input int d, input logic rst, input logic [3:0] pins,
                            input logic [7:0] mode, input logic [3:0] ack);
    logic [3:0]  ev;
    logic [15:0] mask;
    if (rst) begin
      m_s1[d]     = m_idle[d];
      m_s2[d]     = m_idle[d];
      m_stable[d] = m_idle[d];
      m_prev[d]   = m_idle[d];
      m_pend[d]   = '0;
      m_ovf[d]    = '0;
      for (int c = 0; c < 4; c++) m_hist[d][c] = {16{m_idle[d][c]}};
    end else begin
      ev = m_event(d, mode);
      for (int c = 0; c < m_n[d]; c++) begin
        if (ev[c]) begin
          if (m_pend[d][c] && !ack[c]) m_ovf[d][c] = 1'b1;
          else begin
            m_pend[d][c] = 1'b1;
            if (ack[c]) m_ovf[d][c] = 1'b0;
          end
        end else if (ack[c]) begin
          m_pend[d][c] = 1'b0;
          m_ovf[d][c]  = 1'b0;
        end
      end
      m_prev[d] = m_stable[d];
      mask = 16'((17'd1 << m_d[d]) - 17'd1);
      for (int c = 0; c < m_n[d]; c++) begin
        m_hist[d][c] = {m_hist[d][c][14:0], m_s2[d][c]};
        if ((m_hist[d][c] & mask) == (m_stable[d][c] ? 16'd0 : mask))
          m_stable[d][c] = ~m_stable[d][c];
      end
      m_s2[d] = m_s1[d];
      m_s1[d] = pins;
    end
  endtask

  function automatic logic [15:0] exp_v(input int d, input logic [7:0] mode);
    return {m_event(d, mode), m_pend[d], m_ovf[d], m_stable[d]};
  endfunction

  function automatic logic [15:0] obs_a();
    return {bus_a.int_pulse, bus_a.pending, bus_a.overflow, bus_a.level};
  endfunction

  function automatic logic [15:0] obs_b();
    return {2'b00, bus_b.int_pulse, 2'b00, bus_b.pending,
            2'b00, bus_b.overflow, 2'b00, bus_b.level};
  endfunction

  // One clock edge for both instances, then settle past the edge.
  task automatic tick();
    @(posedge clock);
    model_edge(0, reset_a, bus_a.pins_in, bus_a.mode, bus_a.ack);
    model_edge(1, reset_b, {2'b00, bus_b.pins_in}, {4'b0000, bus_b.mode}, {2'b00, bus_b.ack});
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if (obs_a() !== {12'h000, IDLE_A}) begin
      fails++; $display("[TB] FAIL reset_a got=%h want=%h", obs_a(), {12'h000, IDLE_A});
    end
    checks++;
    if (obs_b() !== {14'h0000, IDLE_B}) begin
      fails++; $display("[TB] FAIL reset_b got=%h want=%h", obs_b(), {14'h0000, IDLE_B});
    end
    reset_a = 1'b0;
    reset_b = 1'b0;
    bus_b.mode = 4'b1111;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (bus_b.int_pulse !== 2'b00) begin
        fails++; $display("[TB] FAIL idle_release_b cyc=%0d got=%b want=00", i, bus_b.int_pulse);
      end
      checks++;
      if (obs_a() !== exp_v(0, bus_a.mode)) begin
        fails++; $display("[TB] FAIL reset_model_a cyc=%0d got=%h want=%h", i, obs_a(), exp_v(0, bus_a.mode));
      end
    end
    bus_b.mode = 4'b0000;
  endtask

  task automatic test_glitch();
    logic [15:0] cnt_max;
    cnt_max = '0;
    bus_a.mode = 8'b0000_0011;
    bus_a.pins_in[0] = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (i == 3) bus_a.pins_in[0] = 1'b0;
      tick();
      if (dut_a.g_ch[0].u_chan.cnt > cnt_max) cnt_max = dut_a.g_ch[0].u_chan.cnt;
      checks++;
      if (bus_a.int_pulse[0] !== 1'b0 || bus_a.level[0] !== 1'b0) begin
        fails++; $display("[TB] FAIL glitch cyc=%0d got pulse=%b level=%b want 0 0", i, bus_a.int_pulse[0], bus_a.level[0]);
      end
      checks++;
      if (obs_a() !== exp_v(0, bus_a.mode)) begin
        fails++; $display("[TB] FAIL glitch_model cyc=%0d got=%h want=%h", i, obs_a(), exp_v(0, bus_a.mode));
      end
    end
    checks++;
    if (cnt_max !== 16'd3 || dut_a.g_ch[0].u_chan.cnt !== 16'd0) begin
      fails++; $display("[TB] FAIL glitch_cnt got max=%0d end=%0d want max=3 end=0", cnt_max, dut_a.g_ch[0].u_chan.cnt);
    end
  endtask

  task automatic test_rise();
    int first_pulse;
    int first_pend;
    int n_pulse;
    first_pulse = -1;
    first_pend  = -1;
    n_pulse     = 0;
    bus_a.mode = 8'b0000_0001;
    bus_a.pins_in[0] = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (bus_a.int_pulse[0] === 1'b1) begin
        n_pulse++;
        if (first_pulse < 0) first_pulse = i;
      end
      if (bus_a.pending[0] === 1'b1 && first_pend < 0) first_pend = i;
      checks++;
      if (obs_a() !== exp_v(0, bus_a.mode)) begin
        fails++; $display("[TB] FAIL rise_model cyc=%0d got=%h want=%h", i, obs_a(), exp_v(0, bus_a.mode));
      end
    end
    checks++;
    if (first_pulse != 6 || n_pulse != 1) begin
      fails++; $display("[TB] FAIL rise_timing got first=%0d count=%0d want first=6 count=1", first_pulse, n_pulse);
    end
    checks++;
    if (first_pend != 7 || bus_a.level[0] !== 1'b1) begin
      fails++; $display("[TB] FAIL rise_pending got pend_at=%0d level=%b want 7 1", first_pend, bus_a.level[0]);
    end
  endtask

  task automatic test_both_overflow();
    int n_pulse;
    n_pulse = 0;
    bus_a.mode = 8'b0000_1101;
    bus_a.pins_in[1] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i == 20) bus_a.pins_in[1] = 1'b0;
      tick();
      if (bus_a.int_pulse[1] === 1'b1) n_pulse++;
      checks++;
      if (obs_a() !== exp_v(0, bus_a.mode)) begin
        fails++; $display("[TB] FAIL both_model cyc=%0d got=%h want=%h", i, obs_a(), exp_v(0, bus_a.mode));
      end
    end
    checks++;
    if (n_pulse != 2 || bus_a.pending[1] !== 1'b1 || bus_a.overflow[1] !== 1'b1) begin
      fails++; $display("[TB] FAIL both_overflow got pulses=%0d pend=%b ovf=%b want 2 1 1", n_pulse, bus_a.pending[1], bus_a.overflow[1]);
    end
    bus_a.ack[1] = 1'b1;
    tick();
    bus_a.ack[1] = 1'b0;
    checks++;
    if (bus_a.pending[1] !== 1'b0 || bus_a.overflow[1] !== 1'b0) begin
      fails++; $display("[TB] FAIL ack_clear got pend=%b ovf=%b want 0 0", bus_a.pending[1], bus_a.overflow[1]);
    end
  endtask

  task automatic test_ack_same_cycle();
    logic hit;
    hit = 1'b0;
    bus_a.pins_in[1] = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    bus_a.pins_in[1] = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (bus_a.pending[1] !== 1'b1 || bus_a.overflow[1] !== 1'b1) begin
      fails++; $display("[TB] FAIL ack_setup got pend=%b ovf=%b want 1 1", bus_a.pending[1], bus_a.overflow[1]);
    end
    bus_a.pins_in[1] = 1'b1;
    for (int i = 0; i < 12 && !hit; i++) begin
      tick();
      if (m_event(0, bus_a.mode) & 4'b0010) begin
        hit = 1'b1;
        checks++;
        if (bus_a.int_pulse[1] !== 1'b1) begin
          fails++; $display("[TB] FAIL ack_event_pulse got=%b want=1", bus_a.int_pulse[1]);
        end
        bus_a.ack[1] = 1'b1;
        tick();
        bus_a.ack[1] = 1'b0;
        checks++;
        if (bus_a.pending[1] !== 1'b1 || bus_a.overflow[1] !== 1'b0) begin
          fails++; $display("[TB] FAIL ack_same_cycle got pend=%b ovf=%b want 1 0", bus_a.pending[1], bus_a.overflow[1]);
        end
      end
    end
    checks++;
    if (!hit) begin
      fails++; $display("[TB] FAIL ack_same_cycle_timeout got no event want one within 12 cycles");
    end
  endtask

  task automatic test_simultaneous();
    int n_all;
    int n_part;
    n_all  = 0;
    n_part = 0;
    bus_a.mode    = 8'h55;
    bus_a.pins_in = 4'h0;
    for (int i = 0; i < 10; i++) tick();
    bus_a.ack = 4'hF;
    tick();
    bus_a.ack = 4'h0;
    bus_a.pins_in = 4'hF;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus_a.int_pulse === 4'hF) n_all++;
      else if (bus_a.int_pulse !== 4'h0) n_part++;
      checks++;
      if (obs_a() !== exp_v(0, bus_a.mode)) begin
        fails++; $display("[TB] FAIL simul_model cyc=%0d got=%h want=%h", i, obs_a(), exp_v(0, bus_a.mode));
      end
    end
    checks++;
    if (n_all != 1 || n_part != 0 || bus_a.pending !== 4'hF) begin
      fails++; $display("[TB] FAIL simultaneous got all=%0d partial=%0d pend=%h want 1 0 F", n_all, n_part, bus_a.pending);
    end
  endtask

  task automatic test_idle_high();
    int n0;
    int n1;
    n0 = 0;
    n1 = 0;
    bus_b.pins_in = 2'b11;
    bus_b.mode    = 4'b0010;
    for (int i = 0; i < 24; i++) begin
      if (i == 4) bus_b.mode = 4'b1110;
      if (i == 6) bus_b.mode = 4'b0010;
      tick();
      checks++;
      if (bus_b.int_pulse !== 2'b00) begin
        fails++; $display("[TB] FAIL mode_change_quiet cyc=%0d got=%b want=00", i, bus_b.int_pulse);
      end
    end
    bus_b.pins_in[0] = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (bus_b.int_pulse[0] === 1'b1) n0++;
      checks++;
      if (obs_b() !== exp_v(1, {4'b0000, bus_b.mode})) begin
        fails++; $display("[TB] FAIL fall_model cyc=%0d got=%h want=%h", i, obs_b(), exp_v(1, {4'b0000, bus_b.mode}));
      end
    end
    bus_b.pins_in[1] = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (bus_b.int_pulse[1] === 1'b1) n1++;
    end
    checks++;
    if (n0 != 1 || n1 != 0 || bus_b.level !== 2'b00 || bus_b.pending !== 2'b01) begin
      fails++; $display("[TB] FAIL idle_high got n0=%0d n1=%0d level=%b pend=%b want 1 0 00 01", n0, n1, bus_b.level, bus_b.pending);
    end
  endtask

  task automatic test_reset_midcount();
    bus_b.mode    = 4'b1111;
    bus_b.pins_in = 2'b11;
    for (int i = 0; i < 16; i++) tick();
    checks++;
    if (bus_b.pending !== 2'b11) begin
      fails++; $display("[TB] FAIL midcount_setup got pend=%b want 11", bus_b.pending);
    end
    bus_b.pins_in[0] = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    reset_b = 1'b1;
    bus_b.pins_in = 2'b11;
    tick();
    reset_b = 1'b0;
    checks++;
    if (obs_b() !== {14'h0000, IDLE_B}) begin
      fails++; $display("[TB] FAIL midcount_reset got=%h want=%h", obs_b(), {14'h0000, IDLE_B});
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (obs_b() !== {14'h0000, IDLE_B}) begin
        fails++; $display("[TB] FAIL midcount_after cyc=%0d got=%h want=%h", i, obs_b(), {14'h0000, IDLE_B});
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) bus_a.pins_in[$urandom_range(0, NA-1)] ^= 1'b1;
      if ($urandom_range(0, 9) == 0) bus_b.pins_in[$urandom_range(0, NB-1)] ^= 1'b1;
      if ($urandom_range(0, 19) == 0) bus_a.mode = 8'($urandom);
      if ($urandom_range(0, 19) == 0) bus_b.mode = 4'($urandom);
      bus_a.ack = 4'($urandom) & 4'($urandom) & 4'($urandom);
      bus_b.ack = 2'($urandom) & 2'($urandom) & 2'($urandom);
      reset_a = ($urandom_range(0, 299) == 0);
      reset_b = ($urandom_range(0, 299) == 0);
      tick();
      checks++;
      if (obs_a() !== exp_v(0, bus_a.mode)) begin
        fails++; $display("[TB] FAIL random_a cyc=%0d got=%h want=%h", i, obs_a(), exp_v(0, bus_a.mode));
      end
      checks++;
      if (obs_b() !== exp_v(1, {4'b0000, bus_b.mode})) begin
        fails++; $display("[TB] FAIL random_b cyc=%0d got=%h want=%h", i, obs_b(), exp_v(1, {4'b0000, bus_b.mode}));
      end
    end
    reset_a = 1'b0;
    reset_b = 1'b0;
  endtask

  initial begin
    m_n[0]    = NA;
    m_n[1]    = NB;
    m_d[0]    = DA;
    m_d[1]    = DB;
    m_idle[0] = IDLE_A;
    m_idle[1] = {2'b00, IDLE_B};
    reset_a       = 1'b1;
    reset_b       = 1'b1;
    bus_a.pins_in = '0;
    bus_a.mode    = '0;
    bus_a.ack     = '0;
    bus_b.pins_in = 2'b11;
    bus_b.mode    = '0;
    bus_b.ack     = '0;
    @(negedge clock);
    test_reset();
    test_glitch();
    test_rise();
    test_both_overflow();
    test_ack_same_cycle();
    test_simultaneous();
    test_idle_high();
    test_reset_midcount();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
